// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// op encoding and the per-stage control payload.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Control bits that travel with every beat: occupancy and the carry
  // leaving the most recently completed segment.
  typedef struct packed {
    logic valid;
    logic carry;
  } cla_stage_t;

endpackage

// File: rtl/cla_block.sv
// One BLOCK-bit lookahead group: bit sums from a carry-in plus the group
// propagate/generate used to ripple between neighbouring groups.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             p_o,
  output logic             g_o
);

  logic [BLOCK-1:0] bitP;
  logic [BLOCK-1:0] bitG;
  logic [BLOCK-1:0] carry;
  logic             grpP;
  logic             grpG;

  // Each internal carry comes from the prefix generate/propagate of the
  // bits below it, so no carry waits on its neighbour's carry.
  always_comb begin
    bitP  = a_i ^ b_i;
    bitG  = a_i & b_i;
    grpP  = 1'b1;
    grpG  = 1'b0;
    carry = '0;
    for (int i = 0; i < BLOCK; i++) begin
      carry[i] = grpG | (grpP & cin_i);
      grpG     = bitG[i] | (bitP[i] & grpG);
      grpP     = grpP & bitP[i];
    end
  end

  assign sum_o = bitP ^ carry;
  assign p_o   = grpP;
  assign g_o   = grpG;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, one sum segment per stage
// with valid/ready flow control. Define CLA_SAT_EN to saturate on overflow.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sumout,
  output logic             overf,
  output logic             cout
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;

  cla_stage_t [STAGES:1] ctl_q;
  logic       [STAGES:1] take;
  logic       [STAGES:1] srcValid;
  logic       [STAGES:1] carry_d;
  logic                  slotFree;
  logic                  ovf_d;
  logic                  ovf_q;

  // A stage may load when it, or any stage downstream of it, has room;
  // the last stage frees up whenever the consumer takes its beat.
  always_comb begin
    slotFree = out_ready;
    take     = '0;
    for (int k = STAGES; k >= 1; k--) begin
      slotFree = slotFree | ~ctl_q[k].valid;
      take[k]  = slotFree;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (take[k]) begin
          ctl_q[k].valid <= srcValid[k];
          if (srcValid[k]) ctl_q[k].carry <= carry_d[k];
        end
      end
      if (take[STAGES] && srcValid[STAGES]) ovf_q <= ovf_d;
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int LO = (k - 1) * SEG;
    localparam int BW = WIDTH - LO;

    logic [WIDTH-1:0] srcA;
    logic [BW-1:0]    srcB;
    logic             srcC;
    logic [SEG-1:0]   segSum;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] word_q;

    // Stage 1 applies the subtract invert and carry-in; later stages pick up
    // the upper operand bits and the carry left by the previous stage.
    if (k == 1) begin : g_head
      assign srcA        = in1;
      assign srcB        = (sub == OP_SUB) ? ~in2 : in2;
      assign srcC        = (sub == OP_SUB);
      assign srcValid[k] = in_valid;
    end else begin : g_tail
      assign srcA        = g_stage[k-1].word_q;
      assign srcB        = g_stage[k-1].g_pass.opb_q;
      assign srcC        = ctl_q[k-1].carry;
      assign srcValid[k] = ctl_q[k-1].valid;
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      logic grpCin;
      logic grpP;
      logic grpG;
      logic grpCout;

      if (g == 0) begin : g_cin0
        assign grpCin = srcC;
      end else begin : g_cinN
        assign grpCin = g_grp[g-1].grpCout;
      end

      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a_i   (srcA[LO + g*BLOCK +: BLOCK]),
        .b_i   (srcB[g*BLOCK +: BLOCK]),
        .cin_i (grpCin),
        .sum_o (segSum[g*BLOCK +: BLOCK]),
        .p_o   (grpP),
        .g_o   (grpG)
      );

      assign grpCout = grpG | (grpP & grpCin);
    end

    assign carry_d[k] = g_grp[NGRP-1].grpCout;

    if (k < STAGES) begin : g_pass
      logic [BW-SEG-1:0] opb_q;

      always_comb begin
        word_d            = srcA;
        word_d[LO +: SEG] = segSum;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       opb_q <= '0;
        else if (take[k] && srcValid[k])  opb_q <= srcB[BW-1:SEG];
      end
    end else begin : g_last
      logic ovfRaw;

      // srcA's top bit is still the untouched in1 sign; srcB's top bit is b'.
      assign ovfRaw = (srcA[WIDTH-1] == srcB[BW-1]) & (segSum[SEG-1] != srcA[WIDTH-1]);
      assign ovf_d  = ovfRaw;

      always_comb begin
        word_d            = srcA;
        word_d[LO +: SEG] = segSum;
`ifdef CLA_SAT_EN
        if (ovfRaw) begin
          word_d = srcA[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      assign sumout = word_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                       word_q <= '0;
      else if (take[k] && srcValid[k])  word_q <= word_d;
    end
  end

  assign in_ready  = take[1];
  assign out_valid = ctl_q[STAGES].valid;
  assign overf     = ovf_q;
  assign cout      = ctl_q[STAGES].carry;

endmodule
